mem_wb_skid_reg: RTL and testbench
==================================

# mem_wb_skid_reg

Parametrised MEM→WB pipeline register for the pipelined-plus-cache core, replacing the unconditional flop stage with a valid/ready stage that carries a 2-entry skid buffer. It lets a cache miss in MEM or a stalled WB consumer back-pressure cleanly without dropping a writeback. It supports pipeline flush, and exports the selected writeback result plus a forwarding tap for the hazard unit.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, ALU result, load data and result
- REG_ADDR_WIDTH, 5, destination register index width
- RESULT_SRC_WIDTH, 2, width of the result-select code

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  discard all held and incoming entries
- valid_m  in  1  MEM stage presents an entry
- ready_m  out  1  stage can accept an entry; registered
- PCPlus4_m, ALUResult_m, ReadData_m  in  DATA_WIDTH each  MEM payload
- RegWrite_m  in  1  entry writes the register file
- ResultSrc_m  in  RESULT_SRC_WIDTH  result select
- Rd_m  in  REG_ADDR_WIDTH  destination register
- valid_w  out  1  head entry valid
- ready_w  in  1  WB consumes head entry this cycle
- PCPlus4_w, ALUResult_w, ReadData_w  out  DATA_WIDTH each  head payload
- RegWrite_w  out  1  head RegWrite AND valid_w
- ResultSrc_w  out  RESULT_SRC_WIDTH  head result select
- Rd_w  out  REG_ADDR_WIDTH  head destination
- Result_w  out  DATA_WIDTH  selected writeback value
- fwd_en  out  1  valid_w AND RegWrite_w AND Rd_w≠0
- fwd_rd  out  REG_ADDR_WIDTH  equals Rd_w
- fwd_data  out  DATA_WIDTH  equals Result_w

## Operation
- The stage has a head register (drives the *_w outputs) and a skid register. Occupancy state is EMPTY, ONE or FULL.
- acc = valid_m & ready_m & ~flush; pop = valid_w & ready_w.
- Transitions:
  - EMPTY: acc → ONE, and the entry loads the head.
  - ONE: acc & pop → ONE, and the entry loads the head. acc & ~pop → FULL, and the entry loads the skid. pop & ~acc → EMPTY.
  - FULL: pop → ONE, and the skid moves to the head. acc cannot occur in FULL because ready_m=0.
- ready_m is registered: next ready_m = (next state ≠ FULL).
- flush has priority over all other events. Next state is EMPTY and the incoming entry is dropped. Payload registers keep stale data but all valids are cleared. ready_m becomes 1 next cycle.
- Result_w selects on ResultSrc_w: 00 ALUResult_w, 01 ReadData_w, 10 PCPlus4_w, 11 zero. It is combinational from the head registers.
- RegWrite_w and fwd_en are forced to 0 whenever valid_w=0. WB never writes on a bubble.
- The stage only reorders through FIFO order. Entries leave in acceptance order, and none is lost or duplicated.

## Timing
- Reset (rst_n=0 at an edge): state EMPTY, valid_w=0, ready_m=1. All payload outputs are 0, and Result_w, RegWrite_w and fwd_en are 0. Reset dominates flush and all traffic, including mid-FULL.
- Latency is 1 cycle from acceptance to valid_w when the stage is empty or popping. Throughput is 1 entry per cycle while ready_w=1.
- ready_m drops the cycle after the stage enters FULL. The skid absorbs the one entry accepted in the cycle the head stalled.
- The sender must hold valid_m and its payload stable while ready_m=0. The consumer may drop ready_w at any time.
- Simultaneous flush and pop: the pop is counted by WB only in that cycle, and the stage becomes EMPTY.

## Structure
- A shared package holds:
  - the ResultSrc encodings: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10
  - a packed struct mem_wb_payload_t containing PCPlus4, ALUResult, ReadData, RegWrite, ResultSrc and Rd
- One natural sub-module: skid_reg_2, a generic 2-entry valid/ready skid buffer over a packed payload. The top level adds the result mux, RegWrite gating and forwarding tap.

## Test plan
- Streaming: ready_w=1, 8 back-to-back entries with ALUResult=1..8 and ResultSrc=00. Expect Result_w=1..8 on consecutive cycles starting 1 cycle after the first, with ready_m constantly 1.
- Back-pressure: ready_w=0 while 3 entries are offered. Expect 2 accepted, ready_m=0 from the cycle after the second, and the third held. Release ready_w; all 3 emerge in order with no gap beyond one cycle.
- Flush in FULL: with 2 entries held, assert flush with valid_m=1. Next cycle valid_w=0, RegWrite_w=0 and ready_m=1; the offered entry never appears.
- Result mux and forwarding: ResultSrc 01/10/11 with ReadData=0xDEAD, PCPlus4=0x104 and Rd=0. Expect Result_w=0xDEAD, then 0x104, then 0. fwd_en=0 whenever Rd=0; fwd_en=1 for Rd=5 with RegWrite=1.
- Reset mid-operation: in FULL, drive rst_n=0 for 1 cycle. Expect every output at its reset value the next cycle and clean acceptance afterwards.

Source files
------------

// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared types and encodings for the MEM->WB skid-buffered pipeline register.
// Holds result-select codes, the skid occupancy states and the reference payload layout.
package mem_wb_skid_reg_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    // Field order matches the flat payload packed by mem_wb_skid_reg at default widths.
    typedef struct packed {
        logic [31:0] PCPlus4;
        logic [31:0] ALUResult;
        logic [31:0] ReadData;
        logic        RegWrite;
        logic [1:0]  ResultSrc;
        logic [4:0]  Rd;
    } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_skid_reg_skid.sv
// skid_reg_2: generic 2-entry valid/ready skid buffer with a registered ready and flush.
// The head register drives out_data; the skid register absorbs the entry accepted while the head stalls.
module skid_reg_2
    import mem_wb_skid_reg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_state_t  state_q, state_d;
    logic        ready_q;
    logic [W-1:0] head_q, skid_q;
    logic        acc, pop;
    logic        load_head_in, load_skid, skid_to_head;

    assign acc = in_valid & ready_q & ~flush;
    assign pop = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != OCC_FULL);
        end
    end

    // NOTE: each combinational output is given a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            unique case (state_q)
                OCC_EMPTY: if (acc) state_d = OCC_ONE;
                OCC_ONE: begin
                    if (acc && !pop)      state_d = OCC_FULL;
                    else if (pop && !acc) state_d = OCC_EMPTY;
                end
                OCC_FULL:  if (pop) state_d = OCC_ONE;
                default:   state_d = OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_head_in = 1'b0;
        load_skid    = 1'b0;
        skid_to_head = 1'b0;
        if (!flush) begin
            unique case (state_q)
                OCC_EMPTY: load_head_in = acc;
                OCC_ONE: begin
                    load_head_in = acc & pop;
                    load_skid    = acc & ~pop;
                end
                OCC_FULL:  skid_to_head = pop;
                default: ;
            endcase
        end
    end

    // Payload is cleared on reset so the outputs read zero; flush only drops the valids.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_in)      head_q <= in_data;
            else if (skid_to_head) head_q <= skid_q;
            if (load_skid)         skid_q <= in_data;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = head_q;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready back-pressure and a 2-entry skid buffer.
// Adds the writeback result mux, bubble gating of RegWrite and the hazard-unit forwarding tap.
module mem_wb_skid_reg
    import mem_wb_skid_reg_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int RESULT_SRC_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        valid_m,
    output logic                        ready_m,
    input  logic [DATA_WIDTH-1:0]       PCPlus4_m,
    input  logic [DATA_WIDTH-1:0]       ALUResult_m,
    input  logic [DATA_WIDTH-1:0]       ReadData_m,
    input  logic                        RegWrite_m,
    input  logic [RESULT_SRC_WIDTH-1:0] ResultSrc_m,
    input  logic [REG_ADDR_WIDTH-1:0]   Rd_m,
    output logic                        valid_w,
    input  logic                        ready_w,
    output logic [DATA_WIDTH-1:0]       PCPlus4_w,
    output logic [DATA_WIDTH-1:0]       ALUResult_w,
    output logic [DATA_WIDTH-1:0]       ReadData_w,
    output logic                        RegWrite_w,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrc_w,
    output logic [REG_ADDR_WIDTH-1:0]   Rd_w,
    output logic [DATA_WIDTH-1:0]       Result_w,
    output logic                        fwd_en,
    output logic [REG_ADDR_WIDTH-1:0]   fwd_rd,
    output logic [DATA_WIDTH-1:0]       fwd_data
);

    localparam int PW = 3*DATA_WIDTH + 1 + RESULT_SRC_WIDTH + REG_ADDR_WIDTH;

    logic [PW-1:0] in_payload, out_payload;
    logic          head_regwrite;

    assign in_payload = {PCPlus4_m, ALUResult_m, ReadData_m, RegWrite_m, ResultSrc_m, Rd_m};

    skid_reg_2 #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (valid_m),
        .in_ready  (ready_m),
        .in_data   (in_payload),
        .out_valid (valid_w),
        .out_ready (ready_w),
        .out_data  (out_payload)
    );

    assign {PCPlus4_w, ALUResult_w, ReadData_w, head_regwrite, ResultSrc_w, Rd_w} = out_payload;

    always_comb begin
        Result_w = '0;
        case (ResultSrc_w)
            RESULT_SRC_WIDTH'(RES_ALU): Result_w = ALUResult_w;
            RESULT_SRC_WIDTH'(RES_MEM): Result_w = ReadData_w;
            RESULT_SRC_WIDTH'(RES_PC4): Result_w = PCPlus4_w;
            default:                    Result_w = '0;
        endcase
    end

    // A bubble must never write the register file or forward.
    assign RegWrite_w = head_regwrite & valid_w;
    assign fwd_en     = RegWrite_w & (Rd_w != '0);
    assign fwd_rd     = Rd_w;
    assign fwd_data   = Result_w;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed, table-driven bench for mem_wb_skid_reg: streaming, back-pressure, result mux,
// forwarding, plus hand sequences for flush in FULL and reset in FULL.
module tb_mem_wb_skid_reg;
    import mem_wb_skid_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, valid_m, ready_m, ready_w;
    logic [31:0] PCPlus4_m, ALUResult_m, ReadData_m;
    logic        RegWrite_m;
    logic [1:0]  ResultSrc_m;
    logic [4:0]  Rd_m;
    logic        valid_w, RegWrite_w, fwd_en;
    logic [31:0] PCPlus4_w, ALUResult_w, ReadData_w, Result_w, fwd_data;
    logic [1:0]  ResultSrc_w;
    logic [4:0]  Rd_w, fwd_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_skid_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .valid_m(valid_m), .ready_m(ready_m),
        .PCPlus4_m(PCPlus4_m), .ALUResult_m(ALUResult_m), .ReadData_m(ReadData_m),
        .RegWrite_m(RegWrite_m), .ResultSrc_m(ResultSrc_m), .Rd_m(Rd_m),
        .valid_w(valid_w), .ready_w(ready_w),
        .PCPlus4_w(PCPlus4_w), .ALUResult_w(ALUResult_w), .ReadData_w(ReadData_w),
        .RegWrite_w(RegWrite_w), .ResultSrc_w(ResultSrc_w), .Rd_w(Rd_w),
        .Result_w(Result_w), .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    typedef struct {
        logic        valid_m;
        logic        ready_w;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic        e_valid_w;
        logic        e_ready_m;
        logic        chk_res;
        logic [31:0] e_result;
        logic        e_regwrite_w;
        logic        e_fwd_en;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic r, input logic [31:0] pc4,
                                input logic [31:0] alu, input logic [31:0] rdata,
                                input logic rw, input logic [1:0] rs, input logic [4:0] rd,
                                input logic ev, input logic er, input logic cr,
                                input logic [31:0] eres, input logic erw, input logic ef,
                                input logic [4:0] erd);
        vec_t t;
        t.valid_m = v;   t.ready_w = r;   t.pc4 = pc4;   t.alu = alu;  t.rdata = rdata;
        t.rw = rw;       t.rs = rs;       t.rd = rd;
        t.e_valid_w = ev; t.e_ready_m = er; t.chk_res = cr; t.e_result = eres;
        t.e_regwrite_w = erw; t.e_fwd_en = ef; t.e_rd = erd;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic f, input logic [31:0] alu,
                         input logic rw, input logic [4:0] rd);
        valid_m = v; ready_w = r; flush = f; ALUResult_m = alu;
        RegWrite_m = rw; Rd_m = rd; ResultSrc_m = RES_ALU;
        PCPlus4_m = 32'h0; ReadData_m = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid_w"},     valid_w, 0);
        check({tag, ".ready_m"},     ready_m, 1);
        check({tag, ".RegWrite_w"},  RegWrite_w, 0);
        check({tag, ".fwd_en"},      fwd_en, 0);
        check({tag, ".PCPlus4_w"},   PCPlus4_w, 0);
        check({tag, ".ALUResult_w"}, ALUResult_w, 0);
        check({tag, ".ReadData_w"},  ReadData_w, 0);
        check({tag, ".ResultSrc_w"}, ResultSrc_w, 0);
        check({tag, ".Rd_w"},        Rd_w, 0);
        check({tag, ".Result_w"},    Result_w, 0);
        check({tag, ".fwd_rd"},      fwd_rd, 0);
        check({tag, ".fwd_data"},    fwd_data, 0);
    endtask

    initial begin
        // Streaming: one entry per cycle, Result_w follows one cycle behind.
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 1, 0, i, 0, 0, RES_ALU, 0, 1, 1, 1, i, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, RES_ALU, 0, 0, 1, 0, 0, 0, 0, 0));
        // Back-pressure: third offer held until the skid drains.
        vecs.push_back(mk(1, 0, 0, 11, 0, 0, RES_ALU, 0, 1, 1, 1, 11, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 12, 0, 0, RES_ALU, 0, 1, 0, 1, 11, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 13, 0, 0, RES_ALU, 0, 1, 0, 1, 11, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 13, 0, 0, RES_ALU, 0, 1, 1, 1, 12, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 13, 0, 0, RES_ALU, 0, 1, 1, 1, 13, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, RES_ALU, 0, 0, 1, 0, 0, 0, 0, 0));
        // Result mux and forwarding tap.
        vecs.push_back(mk(1, 1, 32'h104, 7, 32'hDEAD, 1, RES_MEM, 0, 1, 1, 1, 32'hDEAD, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h104, 7, 32'hDEAD, 1, RES_PC4, 0, 1, 1, 1, 32'h104, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h104, 7, 32'hDEAD, 1, 2'b11,   0, 1, 1, 1, 32'h0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h104, 32'h55, 32'hDEAD, 1, RES_ALU, 5, 1, 1, 1, 32'h55, 1, 1, 5));
        vecs.push_back(mk(1, 1, 32'h104, 32'h66, 32'hDEAD, 0, RES_ALU, 5, 1, 1, 1, 32'h66, 0, 0, 5));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, RES_ALU, 0, 0, 1, 0, 0, 0, 0, 0));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            valid_m = vecs[i].valid_m; ready_w = vecs[i].ready_w; flush = 1'b0;
            PCPlus4_m = vecs[i].pc4; ALUResult_m = vecs[i].alu; ReadData_m = vecs[i].rdata;
            RegWrite_m = vecs[i].rw; ResultSrc_m = vecs[i].rs; Rd_m = vecs[i].rd;
            tick();
            check($sformatf("vec%0d.valid_w", i),    valid_w,    vecs[i].e_valid_w);
            check($sformatf("vec%0d.ready_m", i),    ready_m,    vecs[i].e_ready_m);
            check($sformatf("vec%0d.RegWrite_w", i), RegWrite_w, vecs[i].e_regwrite_w);
            check($sformatf("vec%0d.fwd_en", i),     fwd_en,     vecs[i].e_fwd_en);
            if (vecs[i].e_valid_w) begin
                check($sformatf("vec%0d.Rd_w", i),   Rd_w,   vecs[i].e_rd);
                check($sformatf("vec%0d.fwd_rd", i), fwd_rd, vecs[i].e_rd);
            end
            if (vecs[i].chk_res) begin
                check($sformatf("vec%0d.Result_w", i), Result_w, vecs[i].e_result);
                check($sformatf("vec%0d.fwd_data", i), fwd_data, vecs[i].e_result);
            end
        end

        // Flush while FULL: held entries and the offered one are all dropped.
        drive(1, 0, 0, 21, 1, 3); tick();
        drive(1, 0, 0, 22, 1, 3); tick();
        check("flush.pre_ready_m", ready_m, 0);
        drive(1, 0, 1, 23, 1, 3); tick();
        check("flush.valid_w",    valid_w, 0);
        check("flush.RegWrite_w", RegWrite_w, 0);
        check("flush.fwd_en",     fwd_en, 0);
        check("flush.ready_m",    ready_m, 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, 0, 0); tick();
            check($sformatf("flush.drained%0d.valid_w", k), valid_w, 0);
        end
        drive(1, 1, 0, 24, 1, 4); tick();
        check("flush.after.valid_w",  valid_w, 1);
        check("flush.after.Result_w", Result_w, 24);
        drive(0, 1, 0, 0, 0, 0); tick();
        check("flush.after.empty", valid_w, 0);

        // Reset while FULL, with traffic still offered.
        drive(1, 0, 0, 31, 1, 7); tick();
        drive(1, 0, 0, 32, 1, 7); tick();
        check("rstfull.pre_ready_m", ready_m, 0);
        rst_n = 1'b0;
        drive(1, 1, 1, 33, 1, 7); tick();
        check_reset_state("rstfull");
        rst_n = 1'b1;
        drive(1, 1, 0, 34, 1, 7); tick();
        check("rstfull.after.valid_w",  valid_w, 1);
        check("rstfull.after.Result_w", Result_w, 34);
        check("rstfull.after.fwd_en",   fwd_en, 1);
        drive(0, 1, 0, 0, 0, 0); tick();
        check("rstfull.after.empty", valid_w, 0);
        check("rstfull.after.ready_m", ready_m, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
